ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder.sv | 180 ++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: decodes 11-bit frames into scan codes and held-key levels for '1', '2'
// and Space. Define PS2_PARITY_CHECK_EN to drop and flag frames that fail odd parity.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       iResetn,
  input  logic       iPS2Clk,
  input  logic       iPS2Dat,
  output logic       o1,
  output logic       o2,
  output logic       oSpace,
  output logic [7:0] oScanCode,
  output logic       oCodeValid,
  output logic       oParityErr
);

  localparam int unsigned TimeoutW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CodeBreak = 8'hF0;
  localparam logic [7:0] CodeExt   = 8'hE0;
  localparam logic [7:0] CodeKey1  = 8'h16;
  localparam logic [7:0] CodeKey2  = 8'h1E;
  localparam logic [7:0] CodeSpace = 8'h29;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } rx_state_e;

  // Synchronizers and edge detection
  logic [1:0] ps2_clk_sync_q;
  logic [1:0] ps2_dat_sync_q;
  logic       ps2_clk_prev_q;
  logic       ps2_fall;
  logic       ps2_bit;

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      ps2_clk_sync_q <= 2'b11;
      ps2_dat_sync_q <= 2'b11;
      ps2_clk_prev_q <= 1'b1;
    end else begin
      ps2_clk_sync_q <= {ps2_clk_sync_q[0], iPS2Clk};
      ps2_dat_sync_q <= {ps2_dat_sync_q[0], iPS2Dat};
      ps2_clk_prev_q <= ps2_clk_sync_q[1];
    end
  end

  always_comb begin
    ps2_fall = ps2_clk_prev_q & ~ps2_clk_sync_q[1];
    ps2_bit  = ps2_dat_sync_q[1];
  end

  // Frame receiver
  rx_state_e             state_q;
  logic [7:0]            shift_q;
  logic [2:0]            bit_cnt_q;
  logic [TimeoutW-1:0]   timeout_q;
`ifdef PS2_PARITY_CHECK_EN
  logic                  parity_q;
`endif

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      state_q   <= StIdle;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      timeout_q <= '0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q  <= 1'b0;
`endif
    end else if (state_q == StIdle) begin
      timeout_q <= '0;
      if (ps2_fall && !ps2_bit) begin
        state_q   <= StData;
        bit_cnt_q <= 3'd0;
      end
    end else if (!ps2_fall) begin
      // Keyboard stalled mid-frame: abandon the partial frame
      if (timeout_q == TimeoutLast) begin
        state_q   <= StIdle;
        timeout_q <= '0;
      end else begin
        timeout_q <= timeout_q + TimeoutW'(1);
      end
    end else begin
      timeout_q <= '0;
      case (state_q)
        StData: begin
          shift_q   <= {ps2_bit, shift_q[7:1]};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_q <= StParity;
          end
        end
        StParity: begin
`ifdef PS2_PARITY_CHECK_EN
          parity_q <= ps2_bit;
`endif
          state_q  <= StStop;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Frame completion qualifiers
  logic stop_ok;
  logic frame_accept;
  logic frame_par_err;

  always_comb begin
    stop_ok = ps2_fall && (state_q == StStop) && ps2_bit;
`ifdef PS2_PARITY_CHECK_EN
    frame_accept  = stop_ok && (^{shift_q, parity_q});
    frame_par_err = stop_ok && !(^{shift_q, parity_q});
`else
    frame_accept  = stop_ok;
    frame_par_err = 1'b0;
`endif
  end

  // Scan-code decoding and key levels
  logic       break_q;
  logic       ext_q;
  logic       key1_q;
  logic       key2_q;
  logic       space_q;
  logic [7:0] scan_code_q;
  logic       code_valid_q;
  logic       par_err_q;

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      break_q      <= 1'b0;
      ext_q        <= 1'b0;
      key1_q       <= 1'b0;
      key2_q       <= 1'b0;
      space_q      <= 1'b0;
      scan_code_q  <= 8'h00;
      code_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
    end else begin
      code_valid_q <= frame_accept;
      par_err_q    <= frame_par_err;
      if (frame_accept) begin
        scan_code_q <= shift_q;
        if (shift_q == CodeBreak) begin
          break_q <= 1'b1;
        end else if (shift_q == CodeExt) begin
          ext_q <= 1'b1;
        end else begin
          // Extended codes never touch the tracked keys
          if (!ext_q) begin
            case (shift_q)
              CodeKey1:  key1_q  <= !break_q;
              CodeKey2:  key2_q  <= !break_q;
              CodeSpace: space_q <= !break_q;
              default: ;
            endcase
          end
          break_q <= 1'b0;
          ext_q   <= 1'b0;
        end
      end
    end
  end

  assign o1         = key1_q;
  assign o2         = key2_q;
  assign oSpace     = space_q;
  assign oScanCode  = scan_code_q;
  assign oCodeValid = code_valid_q;
  assign oParityErr = par_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scenarios plus randomized frames checked each cycle against
// an event-queue model of held keys and the last scan code.
module tb_ps2_key_decoder;

  localparam int unsigned Timeout = 400;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit ParChk = 1'b1;
`else
  localparam bit ParChk = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       iResetn = 1'b1;
  logic       iPS2Clk = 1'b1;
  logic       iPS2Dat = 1'b1;
  logic       o1;
  logic       o2;
  logic       oSpace;
  logic [7:0] oScanCode;
  logic       oCodeValid;
  logic       oParityErr;

  ps2_key_decoder #(
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clk       (clk),
    .iResetn   (iResetn),
    .iPS2Clk   (iPS2Clk),
    .iPS2Dat   (iPS2Dat),
    .o1        (o1),
    .o2        (o2),
    .oSpace    (oSpace),
    .oScanCode (oScanCode),
    .oCodeValid(oCodeValid),
    .oParityErr(oParityErr)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [7:0]  code;
    int unsigned cyc;
  } ev_t;
  ev_t evq[$];

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int perr_cnt = 0;

  bit         m_brk, m_ext, m_k1, m_k2, m_sp;
  logic [7:0] m_code = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Keyboard semantics: F0 = release prefix, E0 = extended prefix, anything else ends a sequence
  function automatic void apply_byte(input logic [7:0] b);
    m_code = b;
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else begin
      if (!m_ext) begin
        if (b == 8'h16) m_k1 = !m_brk;
        if (b == 8'h1E) m_k2 = !m_brk;
        if (b == 8'h29) m_sp = !m_brk;
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    ev_t e;
    if (!iResetn) begin
      {m_brk, m_ext, m_k1, m_k2, m_sp} = '0;
      m_code = 8'h00;
      evq.delete();
      chk("reset_outputs", {18'd0, o1, o2, oSpace, oCodeValid, oParityErr, oScanCode}, 32'd0);
    end else begin
      if (oCodeValid) begin
        valid_cnt++;
        if (evq.size() == 0) chk("spurious_valid", oCodeValid, 1'b0);
        else begin
          e = evq.pop_front();
          chk("event_is_code", e.is_err, 1'b0);
          chk("scan_code", oScanCode, e.code);
          chk("valid_latency", cyc - e.cyc, 3);
          apply_byte(e.code);
        end
      end
      if (oParityErr) begin
        perr_cnt++;
        if (evq.size() == 0) chk("spurious_parity_err", oParityErr, 1'b0);
        else begin
          e = evq.pop_front();
          chk("event_is_parity_err", e.is_err, 1'b1);
          chk("perr_latency", cyc - e.cyc, 3);
        end
      end
      chk("keys", {o1, o2, oSpace}, {m_k1, m_k2, m_sp});
      chk("scan_hold", oScanCode, m_code);
    end
  end

  task automatic ps2_bit(input logic b, input bit push, input ev_t e);
    ev_t ev;
    ev = e;
    @(negedge clk);
    iPS2Dat = b;
    repeat (3) @(negedge clk);
    iPS2Clk = 1'b0;
    if (push) begin
      ev.cyc = cyc;
      evq.push_back(ev);
    end
    repeat (6) @(negedge clk);
    iPS2Clk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits);
    logic [10:0] f;
    ev_t e;
    bit push;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    e.code = b;
    e.is_err = ParChk && bad_par;
    e.cyc = 0;
    push = (nbits == 11) && !bad_stop;
    for (int i = 0; i < nbits; i++) ps2_bit(f[i], push && (i == 10), e);
    iPS2Dat = 1'b1;
    repeat (2) @(negedge clk);
    chk("event_drained", evq.size(), 0);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 iResetn = 1'b0;
    repeat (3) @(posedge clk);
    #2 iResetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int v0;
    int p0;
    logic [7:0] b;
    #1 iResetn = 1'b0;
    repeat (4) @(posedge clk);
    #2 iResetn = 1'b1;
    @(negedge clk);
    chk("reset_scan", oScanCode, 8'h00);
    chk("reset_o1", o1, 1'b0);

    send(8'h16);
    chk("make16_o1", o1, 1'b1);
    chk("make16_scan", oScanCode, 8'h16);
    chk("make16_valid_count", valid_cnt, 1);
    send(8'hF0);
    chk("f0_o1_still_held", o1, 1'b1);
    send(8'h16);
    chk("break16_o1", o1, 1'b0);

    send(8'h1E);
    send(8'h29);
    chk("make1e_o2", o2, 1'b1);
    chk("make29_space", oSpace, 1'b1);
    send(8'hF0);
    send(8'h1E);
    chk("break1e_o2", o2, 1'b0);
    chk("break1e_space_held", oSpace, 1'b1);

    send(8'hE0);
    send(8'h16);
    chk("ext16_o1", o1, 1'b0);
    send(8'h16);
    chk("plain16_o1", o1, 1'b1);
    send(8'h16);
    chk("typematic16_o1", o1, 1'b1);
    send(8'hF0);
    send(8'h16);

    v0 = valid_cnt;
    p0 = perr_cnt;
    send_frame(8'h16, 1'b1, 1'b0, 11);
    chk("badpar_o1", o1, ParChk ? 1'b0 : 1'b1);
    chk("badpar_valids", valid_cnt - v0, ParChk ? 0 : 1);
    chk("badpar_perrs", perr_cnt - p0, ParChk ? 1 : 0);
    send(8'hF0);
    send(8'h16);
    chk("badpar_release_o1", o1, 1'b0);

    v0 = valid_cnt;
    send_frame(8'h16, 1'b0, 1'b1, 11);
    chk("badstop_valids", valid_cnt - v0, 0);

    send(8'hF0);
    send(8'h29);
    chk("space_released", oSpace, 1'b0);
    send_frame(8'h16, 1'b0, 1'b0, 5);
    repeat (Timeout + 10) @(negedge clk);
    v0 = valid_cnt;
    send(8'h29);
    chk("timeout_space", oSpace, 1'b1);
    chk("timeout_scan", oScanCode, 8'h29);
    chk("timeout_valids", valid_cnt - v0, 1);

    send_frame(8'h16, 1'b0, 1'b0, 4);
    do_reset();
    chk("midreset_keys", {o1, o2, oSpace}, 3'b000);
    v0 = valid_cnt;
    send(8'h1E);
    chk("postreset_o2", o2, 1'b1);
    chk("postreset_scan", oScanCode, 8'h1E);
    chk("postreset_valids", valid_cnt - v0, 1);

    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 7))
        0: b = 8'h16;
        1: b = 8'h1E;
        2: b = 8'h29;
        3: b = 8'hF0;
        4: b = 8'hE0;
        default: b = 8'($urandom);
      endcase
      send_frame(b, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, 11);
    end

    repeat (10) @(negedge clk);
    chk("final_drained", evq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
